// File: rtl/platform_pio_pkg.sv
// Shared definitions for the platform PIO slaves: Avalon word addresses of
// the input-PIO register map and the edge-select encodings for edgecapture.
package platform_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA    = 2'd0,
    PIO_ADDR_RAW     = 2'd1,
    PIO_ADDR_IRQMASK = 2'd2,
    PIO_ADDR_EDGE    = 2'd3
  } pio_addr_e;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit of the key PIO: 2-flop synchronizer, stable-count debounce
// and a one-cycle delayed copy of the debounced level for edge detection.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   in_bit_i     asynchronous external input
//   raw_o        synchronized, pre-debounce level
//   deb_o        debounced level
//   deb_dly_o    debounced level delayed by one clock
module pio_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit_i,
  output logic raw_o,
  output logic deb_o,
  output logic deb_dly_o
);

  logic s1_q, s2_q;
  logic deb;
  logic deb_dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= IDLE_LEVEL;
      s2_q      <= IDLE_LEVEL;
      deb_dly_q <= IDLE_LEVEL;
    end else begin
      s1_q      <= in_bit_i;
      s2_q      <= s1_q;
      deb_dly_q <= deb;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      assign deb = s2_q;
    end else begin : g_deb
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          deb_q, deb_d;

      // Any agreement clears the count, so a short glitch never accumulates;
      // the count never passes CNT_LAST because that value commits or clears.
      always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (s2_q == deb_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          deb_d = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
          deb_q <= IDLE_LEVEL;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign deb = deb_q;
    end
  endgenerate

  assign raw_o     = s2_q;
  assign deb_o     = deb;
  assign deb_dly_o = deb_dly_q;

endmodule

// File: rtl/platform_key_pio.sv
// Avalon-MM input PIO for push-buttons and switches. Each bit is synchronized,
// debounced and edge-detected; software reads levels, masks interrupts and
// clears captured edges write-1-to-clear.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   address[1:0]       word address: 0 data, 1 raw, 2 irqmask, 3 edgecapture
//   chipselect         slave select
//   write_n            active-low write strobe
//   writedata[31:0]    write data
//   readdata[31:0]     read data, registered (latency 1)
//   irq                level interrupt, |(edgecapture & irqmask)
//   in_port[WIDTH-1:0] asynchronous external inputs
module platform_key_pio
  import platform_pio_pkg::*;
#(
  parameter int unsigned     WIDTH           = 8,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter int unsigned     EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] raw, deb, deb_dly;
  logic [WIDTH-1:0] rise, fall, edge_hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL[i])
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .in_bit_i  (in_port[i]),
      .raw_o     (raw[i]),
      .deb_o     (deb[i]),
      .deb_dly_o (deb_dly[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  assign rise = deb & ~deb_dly;
  assign fall = ~deb & deb_dly;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISING:  edge_hit = rise;
      EDGE_FALLING: edge_hit = fall;
      default:      edge_hit = rise | fall;
    endcase
  end

  always_comb begin
    clr       = '0;
    irqmask_d = irqmask_q;
    if (wr_en && address == PIO_ADDR_EDGE)    clr       = writedata[WIDTH-1:0];
    if (wr_en && address == PIO_ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    // OR-ing the edge last lets a same-cycle edge beat the clear.
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
  end

  always_comb begin
    readdata_d = '0;
    if (chipselect) begin
      case (pio_addr_e'(address))
        PIO_ADDR_DATA:    readdata_d = 32'(deb);
        PIO_ADDR_RAW:     readdata_d = 32'(raw);
        PIO_ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
        PIO_ADDR_EDGE:    readdata_d = 32'(edgecap_q);
        default:          readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
